// File: rtl/sipo_rx_if.sv
// Serial-in / parallel-out receiver bus: serial input side plus the parallel word outputs.
// The master drives the serial stream; the slave (the receiver) produces the words.
interface sipo_rx_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             sin;
    logic             sin_en;
    logic             sync;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output sin,
        output sin_en,
        output sync,
        input  pout,
        input  pout_valid,
        input  busy,
        input  word_cnt
    );

    modport slave (
        input  sin,
        input  sin_en,
        input  sync,
        output pout,
        output pout_valid,
        output busy,
        output word_cnt
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB first from a qualified
// serial stream, with a sync strobe to realign and a saturating completed-word counter.
module sipo_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    sipo_rx_if.slave    bus
);
    localparam int BCNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  shreg, shreg_next;
    logic [BCNT_W-1:0] bcnt, bcnt_next;
    logic [WIDTH-1:0]  pout_reg, pout_next;
    logic              valid_reg, valid_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]  shifted;

    assign shifted = {shreg[WIDTH-2:0], bus.sin};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bcnt      <= '0;
            pout_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bcnt      <= bcnt_next;
            pout_reg  <= pout_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    // sync outranks sin_en, so a strobe on the final bit's cycle discards the word
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        bcnt_next  = bcnt;
        pout_next  = pout_reg;
        valid_next = 1'b0;
        cnt_next   = cnt_reg;

        if (bus.sync) begin
            state_next = IDLE;
            shreg_next = '0;
            bcnt_next  = '0;
        end else if (bus.sin_en) begin
            shreg_next = shifted;
            if (state == SHIFT && bcnt == LAST_BIT) begin
                state_next = IDLE;
                bcnt_next  = '0;
                pout_next  = shifted;
                valid_next = 1'b1;
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                state_next = SHIFT;
                bcnt_next  = bcnt + 1'b1;
            end
        end
    end

    assign bus.pout       = pout_reg;
    assign bus.pout_valid = valid_reg;
    assign bus.busy       = (bcnt != '0);
    assign bus.word_cnt   = cnt_reg;
endmodule
